// File: rtl/mux2_1_if.sv
// Bundle of the data-path signals around one mux2_1 instance.
// The mux itself keeps its plain i0/i1/sel/out ports so parents can use
// implicit .name connections; this bundle is for the code driving and observing it.
`timescale 1ns/1ps
interface mux2_1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;

  // Side that supplies the data, select and load enable.
  modport master (
    output i0, i1, sel, en,
    input  out, out_q
  );

  // Side that computes the mux result and its registered copy.
  modport slave (
    input  i0, i1, sel, en,
    output out, out_q
  );
endinterface

// File: rtl/mux2_1.sv
// Two-input multiplexer with a combinational result and an optional registered copy.
// Only out_q uses clk/reset_n/en, so combinational-only users may leave them open.
`timescale 1ns/1ps
module mux2_1 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  logic [WIDTH-1:0] sel_vec;

  assign sel_vec = {WIDTH{sel}};

  // Bitwise and-or mux; the i0&i1 consensus term keeps an unknown select from
  // poisoning bits where both inputs already agree, as a real gate mux would.
  assign out = (sel_vec & i1) | (~sel_vec & i0) | (i0 & i1);

  // Registered copy of out: async active-low reset wins, otherwise load when enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= RESET_VAL;
    end else if (en) begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux2_1.sv
// Directed self-checking bench for mux2_1: 8-bit registered instance,
// a 1-bit instance for the exhaustive truth table, and a 4:1 tree of three instances.
`timescale 1ns/1ps
module tb_mux2_1;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic four_state;

  mux2_1_if #(.WIDTH(8)) bus ();

  mux2_1 #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i0      (bus.i0),
    .i1      (bus.i1),
    .sel     (bus.sel),
    .en      (bus.en),
    .out     (bus.out),
    .out_q   (bus.out_q)
  );

  // 1-bit instance for the exhaustive combinational table
  logic b_i0, b_i1, b_sel, b_out, b_out_q;

  mux2_1 #(.WIDTH(1)) u_bit (
    .clk     (clk),
    .reset_n (reset_n),
    .i0      (b_i0),
    .i1      (b_i1),
    .sel     (b_sel),
    .en      (1'b0),
    .out     (b_out),
    .out_q   (b_out_q)
  );

  // 4:1 tree: two first-level muxes on sel0 feed one second-level mux on sel1
  logic [3:0] q_in;
  logic       q_sel0, q_sel1;
  logic       q_lo, q_hi, q_out;
  logic       q_lo_q, q_hi_q, q_out_q;

  mux2_1 #(.WIDTH(1)) u_lo (
    .clk(clk), .reset_n(reset_n), .i0(q_in[0]), .i1(q_in[1]), .sel(q_sel0),
    .en(1'b0), .out(q_lo), .out_q(q_lo_q)
  );

  mux2_1 #(.WIDTH(1)) u_hi (
    .clk(clk), .reset_n(reset_n), .i0(q_in[2]), .i1(q_in[3]), .sel(q_sel0),
    .en(1'b0), .out(q_hi), .out_q(q_hi_q)
  );

  mux2_1 #(.WIDTH(1)) u_top (
    .clk(clk), .reset_n(reset_n), .i0(q_lo), .i1(q_hi), .sel(q_sel1),
    .en(1'b0), .out(q_out), .out_q(q_out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    bus.en  = 1'b1;
    bus.sel = 1'b1;
    bus.i0  = 8'h11;
    bus.i1  = 8'h5A;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_q !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_immediate: out_q=%h expected=%h", bus.out_q, 8'h00);
    end
    checks++;
    if (bus.out !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL out_during_reset: out=%h expected=%h", bus.out, 8'h5A);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_q !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_held_with_en: out_q=%h expected=%h", bus.out_q, 8'h00);
    end
  endtask

  task automatic test_comb_exhaustive();
    logic [2:0] v;
    logic       expected;
    for (int k = 0; k < 8; k++) begin
      v     = k[2:0];
      b_sel = v[2];
      b_i0  = v[1];
      b_i1  = v[0];
      expected = v[2] ? v[0] : v[1];
      #1;
      checks++;
      if (b_out !== expected) begin
        failures++;
        $display("[TB] FAIL comb_bit sel=%b i0=%b i1=%b: out=%b expected=%b",
                 b_sel, b_i0, b_i1, b_out, expected);
      end
    end
  endtask

  task automatic test_mux4();
    logic [5:0] v;
    logic       expected;
    for (int k = 0; k < 64; k++) begin
      v      = k[5:0];
      q_sel1 = v[5];
      q_sel0 = v[4];
      q_in   = v[3:0];
      case ({v[5], v[4]})
        2'b00:   expected = v[0];
        2'b01:   expected = v[1];
        2'b10:   expected = v[2];
        default: expected = v[3];
      endcase
      #1;
      checks++;
      if (q_out !== expected) begin
        failures++;
        $display("[TB] FAIL mux4 sel=%b%b in=%b: out=%b expected=%b",
                 q_sel1, q_sel0, q_in, q_out, expected);
      end
    end
  endtask

  task automatic test_x_select();
    logic x_probe;
    x_probe    = 1'bx;
    four_state = $isunknown(x_probe);
    bus.sel = 1'bx;
    bus.i0  = 8'hFF;
    bus.i1  = 8'hFF;
    #1;
    checks++;
    if (bus.out !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL xsel_agree_ones: out=%b expected=%b", bus.out, 8'hFF);
    end
    bus.i0 = 8'hA5;
    bus.i1 = 8'hA5;
    #1;
    checks++;
    if (bus.out !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL xsel_agree_mixed: out=%b expected=%b", bus.out, 8'hA5);
    end
    bus.i0 = 8'h0F;
    bus.i1 = 8'hFF;
    #1;
    if (four_state) begin
      checks++;
      if (bus.out !== 8'bxxxx1111) begin
        failures++;
        $display("[TB] FAIL xsel_disagree: out=%b expected=%b", bus.out, 8'bxxxx1111);
      end
    end
    bus.sel = 1'b0;
  endtask

  task automatic test_load_hold();
    @(negedge clk);
    bus.en  = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_q !== 8'h00) begin
      failures++;
      $display("[TB] FAIL release_no_en: out_q=%h expected=%h", bus.out_q, 8'h00);
    end
    @(negedge clk);
    bus.sel = 1'b1;
    bus.i0  = 8'h00;
    bus.i1  = 8'hA5;
    bus.en  = 1'b1;
    #1;
    checks++;
    if (bus.out_q !== 8'h00) begin
      failures++;
      $display("[TB] FAIL before_first_load: out_q=%h expected=%h", bus.out_q, 8'h00);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_q !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL load_a5: out_q=%h expected=%h", bus.out_q, 8'hA5);
    end
    @(negedge clk);
    bus.en = 1'b0;
    bus.i1 = 8'h3C;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_q !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL hold_en0: out_q=%h expected=%h", bus.out_q, 8'hA5);
    end
    checks++;
    if (bus.out !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL out_while_hold: out=%h expected=%h", bus.out, 8'h3C);
    end
  endtask

  task automatic test_async_reset_mid();
    @(negedge clk);
    bus.i1 = 8'hA5;
    bus.en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i1 = 8'h77;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_q !== 8'h00) begin
      failures++;
      $display("[TB] FAIL mid_reset_immediate: out_q=%h expected=%h", bus.out_q, 8'h00);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_q !== 8'h00) begin
        failures++;
        $display("[TB] FAIL mid_reset_hold cycle=%0d: out_q=%h expected=%h", c, bus.out_q, 8'h00);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus.en  = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_q !== 8'h00) begin
      failures++;
      $display("[TB] FAIL post_release_hold: out_q=%h expected=%h", bus.out_q, 8'h00);
    end
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_q !== 8'h77) begin
      failures++;
      $display("[TB] FAIL first_load_after_release: out_q=%h expected=%h", bus.out_q, 8'h77);
    end
  endtask

  task automatic test_late_change();
    @(negedge clk);
    bus.en  = 1'b1;
    bus.sel = 1'b1;
    bus.i0  = 8'h12;
    bus.i1  = 8'h34;
    #4;
    bus.sel = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_q !== 8'h12) begin
      failures++;
      $display("[TB] FAIL late_sel_change: out_q=%h expected=%h", bus.out_q, 8'h12);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    vals[0] = 8'h01;
    vals[1] = 8'h80;
    vals[2] = 8'hC3;
    vals[3] = 8'h5E;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.en  = 1'b1;
      bus.sel = k[0];
      bus.i0  = k[0] ? 8'hEE : vals[k];
      bus.i1  = k[0] ? vals[k] : 8'hEE;
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_q !== vals[k]) begin
        failures++;
        $display("[TB] FAIL back_to_back k=%0d: out_q=%h expected=%h", k, bus.out_q, vals[k]);
      end
    end
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  task automatic test_width_independence();
    logic [7:0] one_hot;
    bus.i0 = 8'hF0;
    bus.i1 = 8'h0F;
    for (int t = 0; t < 4; t++) begin
      bus.sel = t[0];
      #0;
      #0;
      checks++;
      if (bus.out !== (t[0] ? 8'h0F : 8'hF0)) begin
        failures++;
        $display("[TB] FAIL toggle_sel t=%0d: out=%h expected=%h", t, bus.out,
                 t[0] ? 8'h0F : 8'hF0);
      end
      #1;
    end
    bus.sel = 1'b1;
    bus.i0  = 8'h00;
    for (int b = 0; b < 8; b++) begin
      one_hot = 8'h01 << b;
      bus.i1  = one_hot;
      #1;
      checks++;
      if (bus.out !== one_hot) begin
        failures++;
        $display("[TB] FAIL bit_isolation b=%0d: out=%h expected=%h", b, bus.out, one_hot);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b1;
    bus.i0   = 8'h00;
    bus.i1   = 8'h00;
    bus.sel  = 1'b0;
    bus.en   = 1'b0;
    b_i0 = 1'b0; b_i1 = 1'b0; b_sel = 1'b0;
    q_in = 4'h0; q_sel0 = 1'b0; q_sel1 = 1'b0;

    test_reset();
    test_comb_exhaustive();
    test_mux4();
    test_x_select();
    test_load_hold();
    test_async_reset_mid();
    test_late_change();
    test_back_to_back();
    test_width_independence();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: time=%0t limit=%0d", $time, 100000);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mux2_1.md
MUX2_1 -- requirements
Module: mux2_1

Interface
- REQ-001: Parameter WIDTH, default 1, is the data width of i0, i1, out and out_q.
- REQ-002: Parameter RESET_VAL, default all-zeros, is the value out_q takes on reset.
- REQ-003: clk  input  1  sole clock; rising-edge active; used only by out_q.
- REQ-004: reset_n  input  1  reset, asynchronous, active-low; acts only on out_q.
- REQ-005: i0  input  WIDTH  data input selected when sel=0.
- REQ-006: i1  input  WIDTH  data input selected when sel=1.
- REQ-007: sel  input  1  select; 0 -> i0, 1 -> i1.
- REQ-008: en  input  1  load enable for out_q.
- REQ-009: out  output  WIDTH  combinational mux result.
- REQ-010: out_q  output  WIDTH  registered copy of out.
- REQ-011: Port names i0, i1, sel and out SHALL be exactly as listed, so that parents can connect them by implicit name (.out, .i0, .i1, .sel).
- REQ-012: Parent muxes that need only the combinational path SHALL be able to leave clk, reset_n, en and out_q unconnected.

Function
- REQ-013: out SHALL equal i0 when sel=0 and i1 when sel=1.
- REQ-014: out SHALL be purely combinational from i0, i1 and sel, with zero clock latency.
- REQ-015: out SHALL NOT depend on clk, reset_n or en.
- REQ-016: Each bit of out SHALL depend only on the same bit of i0 and i1; there SHALL be no cross-bit interaction.
- REQ-017: When sel is X or Z, each out bit SHALL equal i0 where i0==i1 on that bit, and SHALL be X otherwise.
- REQ-018: The behaviour in REQ-017 SHALL match gate-level (sel&i1)|(~sel&i0) semantics without pessimism.
- REQ-019: On a rising clk edge with en=1 and reset_n=1, out_q SHALL load the current out value; load latency is 1 cycle.
- REQ-020: On a rising clk edge with en=0 and reset_n=1, out_q SHALL hold its value.
- REQ-021: If sel, i0 or i1 change in the same cycle as the load, out_q SHALL capture the settled out value present at the edge.
- REQ-022: The block SHALL have no other state, no handshake and no arithmetic.
- REQ-023: A 4:1 mux built from three instances SHALL produce i[{sel1,sel0}]: two first-level instances on sel0 feed one second-level instance on sel1.

Reset
- REQ-024: When reset_n=0, out_q SHALL take RESET_VAL immediately, without waiting for a clk edge.
- REQ-025: out_q SHALL hold RESET_VAL for as long as reset_n=0, whatever clk and en do.
- REQ-026: out is unaffected by reset and SHALL keep following REQ-013 throughout reset.
- REQ-027: On reset_n deassertion, out_q SHALL keep RESET_VAL until the first rising clk edge with en=1.
- REQ-028: Reset asserted mid-operation SHALL override any load pending in that cycle.

Verification
- REQ-029: Exhaustive combinational check, WIDTH=1: all 8 values of {sel,i0,i1} -> out equals i0 when sel=0 and i1 when sel=1. Example: sel=1, i0=0, i1=1 -> out=1.
- REQ-030: 4:1 composition check: all 64 values of {sel1,sel0,i0,i1,i2,i3} -> out=i[{sel1,sel0}]. Example: sel1=1, sel0=0, i2=1, others 0 -> out=1.
- REQ-031: X-select check: sel=X with i0=i1=1 -> out=1; sel=X with i0=0, i1=1 -> out=X.
- REQ-032: Register check, WIDTH=8: reset_n=0 -> out_q=0x00 immediately. Then release reset, set sel=1, i1=0xA5, en=1, one edge -> out_q=0xA5. Then en=0, i1=0x3C, edge -> out_q stays 0xA5.
- REQ-033: Async reset mid-operation: with out_q=0xA5, pull reset_n low between edges -> out_q=0x00 at once, and it stays 0x00 through clocks with en=1 until release.
- REQ-034: Width and independence check, WIDTH=8: i0=0xF0, i1=0x0F, toggle sel -> out alternates 0xF0 and 0x0F with no clock, and matches in the same delta.
